// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RV32I-subset core: sequences fetch/decode/execute,
// drives ALU_Control and datapath selects, stalls on mem_ready and counts retired instructions.
module multicycle_control #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             ALUOp1,
  output logic             ALUOp0,
  output logic [3:0]       funct,
  output logic             pc_write,
  output logic             ir_write,
  output logic             adr_src,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       result_src,
  output logic             instr_done,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BEQ, TRAP
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [1:0] alu_op;
  logic       pc_write_raw;
  logic       ir_write_raw;
  logic       mem_write_raw;
  logic       reg_write_raw;
  logic       instr_done_raw;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_next;
  end

  // Next-state and Moore decode (a few enables qualified by mem_ready/zero)
  always_comb begin
    state_next     = state;
    alu_op         = 2'b00;
    pc_write_raw   = 1'b0;
    ir_write_raw   = 1'b0;
    mem_write_raw  = 1'b0;
    reg_write_raw  = 1'b0;
    instr_done_raw = 1'b0;
    adr_src        = 1'b0;
    mem_read       = 1'b0;
    alu_src_a      = 2'b00;
    alu_src_b      = 2'b00;
    result_src     = 2'b00;
    case (state)
      FETCH: begin
        mem_read     = 1'b1;
        alu_src_b    = 2'b10;
        result_src   = 2'b10;
        pc_write_raw = mem_ready;
        ir_write_raw = mem_ready;
        if (mem_ready) state_next = DECODE;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (opcode)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_R:         state_next = EXECR;
          OP_I:         state_next = EXECI;
          OP_BEQ:       state_next = BEQ;
          default:      state_next = TRAP;
        endcase
      end
      MEMADR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        state_next = (opcode == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        mem_read = 1'b1;
        adr_src  = 1'b1;
        if (mem_ready) state_next = MEMWB;
      end
      MEMWB: begin
        reg_write_raw  = 1'b1;
        result_src     = 2'b01;
        instr_done_raw = 1'b1;
        state_next     = FETCH;
      end
      MEMWRITE: begin
        mem_write_raw  = 1'b1;
        adr_src        = 1'b1;
        instr_done_raw = mem_ready;
        if (mem_ready) state_next = FETCH;
      end
      EXECR: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b10;
        state_next = ALUWB;
      end
      EXECI: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        state_next = ALUWB;
      end
      ALUWB: begin
        reg_write_raw  = 1'b1;
        instr_done_raw = 1'b1;
        state_next     = FETCH;
      end
      BEQ: begin
        alu_src_a      = 2'b10;
        alu_op         = 2'b01;
        pc_write_raw   = zero;
        instr_done_raw = 1'b1;
        state_next     = FETCH;
      end
      TRAP:    state_next = TRAP;
      default: state_next = FETCH;
    endcase
  end

  // Architectural writes are suppressed for as long as reset is held
  assign pc_write   = rst_n & pc_write_raw;
  assign ir_write   = rst_n & ir_write_raw;
  assign mem_write  = rst_n & mem_write_raw;
  assign reg_write  = rst_n & reg_write_raw;
  assign instr_done = rst_n & instr_done_raw;

  assign ALUOp1 = alu_op[1];
  assign ALUOp0 = alu_op[0];
  assign funct  = {funct7_5, funct3};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  illegal <= 1'b0;
    else if (state_next == TRAP) illegal <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          instret <= '0;
    else if (instr_done) instret <= instret + CNT_W'(1);
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: builds each instruction's expected phase sequence from its class
// and stall pattern, then checks every cycle's outputs against the phase's required controls.
module tb_multicycle_control;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned CNT_MOD = 1 << CNT_W;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] AI  = 7'b0010011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] BAD = 7'b1111111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic funct7_5 = 1'b0;
  logic zero = 1'b0;
  logic mem_ready = 1'b1;
  logic ALUOp1, ALUOp0, pc_write, ir_write, adr_src, mem_read, mem_write, reg_write;
  logic instr_done, illegal;
  logic [3:0] funct;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [CNT_W-1:0] instret;

  always #5 clk = ~clk;

  multicycle_control #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .mem_ready(mem_ready), .ALUOp1(ALUOp1), .ALUOp0(ALUOp0), .funct(funct),
    .pc_write(pc_write), .ir_write(ir_write), .adr_src(adr_src), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .result_src(result_src), .instr_done(instr_done),
    .illegal(illegal), .instret(instret)
  );

  logic [14:0] dut_ctrl;
  assign dut_ctrl = {ALUOp1, ALUOp0, pc_write, ir_write, adr_src, mem_read, mem_write,
                     reg_write, alu_src_a, alu_src_b, result_src, instr_done};

  typedef enum int {P_F, P_D, P_MA, P_MR, P_MWB, P_MW, P_ER, P_EI, P_AWB, P_BEQ, P_TRAP} ph_t;

  int n_chk = 0;
  int n_pass = 0;
  int model_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Required control outputs for one phase of an instruction
  function automatic logic [14:0] exp_ctrl(input ph_t p, input logic mr, input logic z);
    logic [1:0] aop, a, b, rs;
    logic pcw, irw, adr, mrd, mwr, rw, dn;
    aop = 2'b00; a = 2'b00; b = 2'b00; rs = 2'b00;
    pcw = 0; irw = 0; adr = 0; mrd = 0; mwr = 0; rw = 0; dn = 0;
    case (p)
      P_F:   begin mrd = 1; b = 2'b10; rs = 2'b10; pcw = mr; irw = mr; end
      P_D:   begin a = 2'b01; b = 2'b01; end
      P_MA:  begin a = 2'b10; b = 2'b01; end
      P_MR:  begin mrd = 1; adr = 1; end
      P_MWB: begin rw = 1; rs = 2'b01; dn = 1; end
      P_MW:  begin mwr = 1; adr = 1; dn = mr; end
      P_ER:  begin a = 2'b10; aop = 2'b10; end
      P_EI:  begin a = 2'b10; b = 2'b01; end
      P_AWB: begin rw = 1; dn = 1; end
      P_BEQ: begin a = 2'b10; aop = 2'b01; pcw = z; dn = 1; end
      default: ;
    endcase
    return {aop, pcw, irw, adr, mrd, mwr, rw, a, b, rs, dn};
  endfunction

  task automatic do_cycle(input ph_t p, input logic mr);
    logic [14:0] e;
    @(negedge clk);
    mem_ready = mr;
    #1;
    e = exp_ctrl(p, mr, zero);
    chk($sformatf("ctrl@%s", p.name()), 32'(dut_ctrl), 32'(e));
    chk($sformatf("funct@%s", p.name()), 32'(funct), 32'({funct7_5, funct3}));
    chk($sformatf("instret@%s", p.name()), 32'(instret), 32'(model_cnt));
    chk($sformatf("illegal@%s", p.name()), 32'(illegal), 32'(p == P_TRAP));
    if (e[0]) model_cnt = (model_cnt + 1) % CNT_MOD;
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic z, input int fs, input int ms);
    opcode = op; funct3 = f3; funct7_5 = f7; zero = z;
    for (int i = 0; i < fs; i++) do_cycle(P_F, 1'b0);
    do_cycle(P_F, 1'b1);
    do_cycle(P_D, rnd());
    case (op)
      LW: begin
        do_cycle(P_MA, rnd());
        for (int i = 0; i < ms; i++) do_cycle(P_MR, 1'b0);
        do_cycle(P_MR, 1'b1);
        do_cycle(P_MWB, rnd());
      end
      SW: begin
        do_cycle(P_MA, rnd());
        for (int i = 0; i < ms; i++) do_cycle(P_MW, 1'b0);
        do_cycle(P_MW, 1'b1);
      end
      RT: begin do_cycle(P_ER, rnd()); do_cycle(P_AWB, rnd()); end
      AI: begin do_cycle(P_EI, rnd()); do_cycle(P_AWB, rnd()); end
      BQ: do_cycle(P_BEQ, rnd());
      default: ;
    endcase
  endtask

  // Literal check of instret just after the edge that retires the last instruction
  task automatic chk_cnt(input string name, input int exp);
    @(posedge clk);
    #1;
    chk(name, 32'(instret), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_pc_write", 32'(pc_write), 32'(0));
    chk("rst_ir_write", 32'(ir_write), 32'(0));
    chk("rst_instr_done", 32'(instr_done), 32'(0));
    chk("rst_instret", 32'(instret), 32'(0));
    chk("rst_illegal", 32'(illegal), 32'(0));
    @(posedge clk); #1 rst_n = 1'b1;

    run_instr(RT, 3'b000, 1'b1, 1'b0, 0, 0);   // sub
    chk_cnt("instret_after_sub", 1);
    run_instr(LW, 3'b010, 1'b0, 1'b0, 0, 2);
    run_instr(BQ, 3'b000, 1'b0, 1'b1, 0, 0);
    run_instr(BQ, 3'b000, 1'b0, 1'b0, 0, 0);
    chk_cnt("instret_after_beqs", 4);
    run_instr(RT, 3'b111, 1'b0, 1'b0, 0, 0);   // and
    run_instr(RT, 3'b110, 1'b0, 1'b0, 1, 0);   // or, fetch stall
    run_instr(RT, 3'b101, 1'b0, 1'b1, 0, 0);   // srl
    run_instr(SW, 3'b010, 1'b0, 1'b0, 1, 2);
    chk_cnt("instret_after_sw", 8);

    // Reset asserted mid-store while stalled: write must drop without a clock edge
    opcode = SW; funct3 = 3'b010; funct7_5 = 1'b0;
    do_cycle(P_F, 1'b1);
    do_cycle(P_D, 1'b1);
    do_cycle(P_MA, 1'b1);
    do_cycle(P_MW, 1'b0);
    @(negedge clk);
    mem_ready = 1'b0;
    #1 chk("mw_before_rst", 32'(mem_write), 32'(1));
    #1 rst_n = 1'b0;
    #1;
    chk("mw_async_drop", 32'(mem_write), 32'(0));
    chk("instret_async_clr", 32'(instret), 32'(0));
    mem_ready = 1'b1;
    #1;
    chk("rst_pc_write_forced", 32'(pc_write), 32'(0));
    chk("rst_ir_write_forced", 32'(ir_write), 32'(0));
    model_cnt = 0;
    @(posedge clk); #1 rst_n = 1'b1;

    for (int i = 0; i < 15; i++) run_instr(AI, 3'b000, 1'b0, 1'b0, 0, 0);
    chk_cnt("instret_15", 15);
    run_instr(AI, 3'b000, 1'b0, 1'b0, 0, 0);
    chk_cnt("instret_wrap", 0);
    run_instr(AI, 3'b000, 1'b0, 1'b0, 0, 0);

    opcode = BAD; funct3 = 3'b000; funct7_5 = 1'b0;
    do_cycle(P_F, 1'b1);
    do_cycle(P_D, 1'b1);
    for (int i = 0; i < 12; i++) do_cycle(P_TRAP, rnd());
    chk_cnt("instret_trap_frozen", 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk("illegal_cleared", 32'(illegal), 32'(0));
    model_cnt = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    run_instr(RT, 3'b000, 1'b0, 1'b0, 0, 0);   // add after trap recovery
    chk_cnt("instret_after_recover", 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
